// File: rtl/pe_drain_quant.sv
// Captures one PE row, then streams N requantized words (bias, optional leaky ReLU, round, saturate).
// Word 0 appears 1 cycle after capture; out_ready=0 holds the presented word; captures are blocked while streaming.
module pe_drain_quant #(
  parameter int N     = 4,
  parameter int WIDTH = 16,
  parameter int SHIFT = 8,
  parameter int OUT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cap_valid,
  output logic                 cap_ready,
  input  logic [N*WIDTH-1:0]   c_bus,
  input  logic [WIDTH-1:0]     bias,
  input  logic                 leaky_en,
  output logic                 acc_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  output logic                 out_last
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = WIDTH + 3;
  localparam int MAXI = 2 ** (OUT_W - 1) - 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic signed [SW-1:0] RND  = SW'(1) <<< (SHIFT - 1);
  localparam logic signed [SW-1:0] MAXV = SW'(MAXI);
  localparam logic signed [SW-1:0] MINV = SW'(-MAXI - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t               state_q, state_d;
  logic [N*WIDTH-1:0]   buf_q, buf_d;
  logic [WIDTH-1:0]     bias_q, bias_d;
  logic                 leaky_q, leaky_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 vld_q, vld_d;
  logic                 last_q, last_d;
  logic                 clr_q, clr_d;
  logic [OUT_W-1:0]     dat_q, dat_d;
  logic [IW-1:0]        nxt_idx;
  logic [WIDTH-1:0]     nxt_word;

  // Three guard bits keep sum and rounding offset free of overflow.
  function automatic logic [OUT_W-1:0] quant(input logic [WIDTH-1:0] c,
                                             input logic [WIDTH-1:0] b,
                                             input logic             lk);
    logic signed [SW-1:0] s;
    logic signed [SW-1:0] r;
    s = $signed({{3{c[WIDTH-1]}}, c}) + $signed({{3{b[WIDTH-1]}}, b});
    if (lk && s[SW-1]) s = s >>> 3;
    r = (s + RND) >>> SHIFT;
    if (r > MAXV)      r = MAXV;
    else if (r < MINV) r = MINV;
    return r[OUT_W-1:0];
  endfunction

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    bias_d   = bias_q;
    leaky_d  = leaky_q;
    idx_d    = idx_q;
    vld_d    = vld_q;
    last_d   = last_q;
    dat_d    = dat_q;
    clr_d    = 1'b0;
    nxt_idx  = idx_q + 1'b1;
    nxt_word = buf_q[nxt_idx*WIDTH +: WIDTH];
    case (state_q)
      IDLE: begin
        if (cap_valid) begin
          buf_d   = c_bus;
          bias_d  = bias;
          leaky_d = leaky_en;
          idx_d   = '0;
          clr_d   = 1'b1;
          // Word 0 is computed straight from the inputs to hit 1-cycle latency.
          vld_d   = 1'b1;
          dat_d   = quant(c_bus[WIDTH-1:0], bias, leaky_en);
          last_d  = (N == 1);
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (!vld_q || out_ready) begin
          if (idx_q == LAST) begin
            vld_d   = 1'b0;
            last_d  = 1'b0;
            state_d = IDLE;
          end else begin
            idx_d  = nxt_idx;
            dat_d  = quant(nxt_word, bias_q, leaky_q);
            last_d = (nxt_idx == LAST);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      bias_q  <= '0;
      leaky_q <= 1'b0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      clr_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      bias_q  <= bias_d;
      leaky_q <= leaky_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      clr_q   <= clr_d;
      dat_q   <= dat_d;
    end
  end

  assign cap_ready = (state_q == IDLE);
  assign acc_clr   = clr_q;
  assign out_valid = vld_q;
  assign out_data  = dat_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_pe_drain_quant.sv
// Directed bench for pe_drain_quant (N=4, WIDTH=16, SHIFT=8, OUT_W=8); expected words hand-computed.
module tb_pe_drain_quant;

  logic        clk;
  logic        rst;
  logic        cap_valid;
  logic        cap_ready;
  logic [63:0] c_bus;
  logic [15:0] bias;
  logic        leaky_en;
  logic        acc_clr;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;

  int tests;
  int fails;

  pe_drain_quant #(.N(4), .WIDTH(16), .SHIFT(8), .OUT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cap_valid (cap_valid),
    .cap_ready (cap_ready),
    .c_bus     (c_bus),
    .bias      (bias),
    .leaky_en  (leaky_en),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_c(input int a, input int b, input int c, input int d);
    c_bus = {16'(d), 16'(c), 16'(b), 16'(a)};
  endtask

  task automatic chk_word(input string tag, input int dat, input int last);
    chk({tag, "_vld"}, int'(out_valid), 1);
    chk({tag, "_dat"}, int'($signed(out_data)), dat);
    chk({tag, "_last"}, int'(out_last), last);
  endtask

  task automatic capture();
    cap_valid = 1'b1;
    tick();
    cap_valid = 1'b0;
  endtask

  task automatic drain_idle(input string tag);
    repeat (4) tick();
    chk({tag, "_idle_vld"}, int'(out_valid), 0);
    chk({tag, "_idle_rdy"}, int'(cap_ready), 1);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    cap_valid = 1'b0;
    out_ready = 1'b1;
    c_bus = '0;
    bias = '0;
    leaky_en = 1'b0;

    #3;
    chk("rst_vld", int'(out_valid), 0);
    chk("rst_dat", int'($signed(out_data)), 0);
    chk("rst_last", int'(out_last), 0);
    chk("rst_clr", int'(acc_clr), 0);
    chk("rst_caprdy", int'(cap_ready), 1);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Basic row: (c+128)>>8 gives 1,-1,2,0.
    set_c(256, -256, 384, 0);
    capture();
    chk_word("basic_w0", 1, 0);
    chk("basic_clr0", int'(acc_clr), 1);
    chk("basic_caprdy", int'(cap_ready), 0);
    tick();
    chk_word("basic_w1", -1, 0);
    chk("basic_clr1", int'(acc_clr), 0);
    tick();
    chk_word("basic_w2", 2, 0);
    chk("basic_clr2", int'(acc_clr), 0);
    tick();
    chk_word("basic_w3", 0, 1);
    tick();
    chk("basic_end_vld", int'(out_valid), 0);
    chk("basic_end_last", int'(out_last), 0);
    chk("basic_end_rdy", int'(cap_ready), 1);
    chk("basic_end_clr", int'(acc_clr), 0);

    // Saturation at both rails.
    set_c(32767, 0, 0, 0);
    bias = 16'sd32767;
    capture();
    chk_word("sat_pos", 127, 0);
    drain_idle("sat_pos");
    set_c(-32768, 0, 0, 0);
    bias = 16'h8000;
    capture();
    chk_word("sat_neg", -128, 0);
    drain_idle("sat_neg");

    // Leaky ReLU: -8192>>>3=-1024 -> -4; plain -8192 -> -32.
    bias = '0;
    set_c(-8192, 0, 0, 0);
    leaky_en = 1'b1;
    capture();
    leaky_en = 1'b0;
    chk_word("leaky_on", -4, 0);
    drain_idle("leaky_on");
    capture();
    chk_word("leaky_off", -32, 0);
    drain_idle("leaky_off");

    // Stall at word 1 with a stray capture attempt.
    set_c(256, 512, 768, 1024);
    capture();
    chk_word("stall_w0", 1, 0);
    tick();
    chk_word("stall_w1", 2, 0);
    out_ready = 1'b0;
    set_c(-256, -256, -256, -256);
    cap_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_word("stall_hold", 2, 0);
      chk("stall_caprdy", int'(cap_ready), 0);
    end
    cap_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk_word("stall_w2", 3, 0);
    tick();
    chk_word("stall_w3", 4, 1);
    tick();
    chk("stall_end_vld", int'(out_valid), 0);
    tick();
    chk("stall_noextra", int'(out_valid), 0);

    // Asynchronous reset mid-row.
    set_c(256, 512, 768, 1024);
    capture();
    tick();
    tick();
    chk_word("arst_w2", 3, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_vld", int'(out_valid), 0);
    chk("arst_dat", int'($signed(out_data)), 0);
    chk("arst_last", int'(out_last), 0);
    chk("arst_clr", int'(acc_clr), 0);
    chk("arst_caprdy", int'(cap_ready), 1);
    tick();
    rst = 1'b1;
    tick();
    set_c(512, 1280, 0, 0);
    capture();
    chk_word("arst_new_w0", 2, 0);
    tick();
    chk_word("arst_new_w1", 5, 0);
    repeat (3) tick();
    chk("arst_new_end", int'(out_valid), 0);

    // Back-to-back rows: capture in the first IDLE cycle.
    set_c(256, -256, 384, 0);
    capture();
    tick();
    tick();
    tick();
    chk_word("b2b_a_w3", 0, 1);
    tick();
    chk("b2b_idle_rdy", int'(cap_ready), 1);
    chk("b2b_idle_vld", int'(out_valid), 0);
    set_c(768, 0, 0, 0);
    capture();
    chk_word("b2b_b_w0", 3, 0);
    chk("b2b_b_clr", int'(acc_clr), 1);
    drain_idle("b2b_b");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
